// File: rtl/counter_cmd_sequencer.sv
// Command sequencer for the 4-bit up/down counter: buffers {op, data, rep}
// commands in a FIFO and expands each one into registered counter controls.
module counter_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_data,
  input  logic [REP_W-1:0] cmd_rep,
  output logic             cnt_rst_n,
  output logic             enable,
  output logic             load,
  output logic             up_down_n,
  output logic [3:0]       data_input,
  output logic             busy,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 6 + REP_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_UP    = 2'b10,
    OP_DOWN  = 2'b11
  } op_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             empty;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;
  op_t              head_op;
  logic [3:0]       head_data;
  logic [REP_W-1:0] head_rep;
  state_t           state;
  logic [REP_W-1:0] rem;

  assign empty     = (count == '0);
  // Ready looks only at occupancy, so a full FIFO stays closed even on a pop edge.
  assign cmd_ready = !rst && (count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = !rst && !empty && ((state == IDLE) || (rem == '0));
  assign busy      = (state == RUN) || !empty;

  assign head      = mem[rd_ptr];
  assign head_op   = op_t'(head[EW-1 -: 2]);
  assign head_data = head[REP_W +: 4];
  assign head_rep  = head[REP_W-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_data, cmd_rep};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // rem counts extra cycles still owed after the current one; done marks rem reaching 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      cnt_rst_n  <= 1'b1;
      enable     <= 1'b0;
      load       <= 1'b0;
      up_down_n  <= 1'b1;
      data_input <= '0;
      done       <= 1'b0;
    end else if (pop) begin
      state     <= RUN;
      rem       <= '0;
      cnt_rst_n <= 1'b1;
      enable    <= 1'b1;
      load      <= 1'b0;
      up_down_n <= 1'b1;
      done      <= 1'b1;
      unique case (head_op)
        OP_CLEAR: begin
          cnt_rst_n <= 1'b0;
          enable    <= 1'b0;
        end
        OP_LOAD: begin
          load       <= 1'b1;
          data_input <= head_data;
        end
        OP_UP: begin
          rem  <= head_rep;
          done <= (head_rep == '0);
        end
        OP_DOWN: begin
          up_down_n <= 1'b0;
          rem       <= head_rep;
          done      <= (head_rep == '0);
        end
      endcase
    end else if ((state == RUN) && (rem != '0)) begin
      rem  <= rem - 1'b1;
      done <= (rem == REP_W'(1));
    end else begin
      state     <= IDLE;
      rem       <= '0;
      cnt_rst_n <= 1'b1;
      enable    <= 1'b0;
      load      <= 1'b0;
      up_down_n <= 1'b1;
      done      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Directed bench for counter_cmd_sequencer: reset, single commands, back-to-back
// execution, FIFO back-pressure and reset abort, checked with immediate assertions.
module tb_counter_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] cmd_rep;
  logic       cnt_rst_n;
  logic       enable;
  logic       load;
  logic       up_down_n;
  logic [3:0] data_input;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  counter_cmd_sequencer #(.DEPTH(4), .REP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_rep    (cmd_rep),
    .cnt_rst_n  (cnt_rst_n),
    .enable     (enable),
    .load       (load),
    .up_down_n  (up_down_n),
    .data_input (data_input),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Completed-command log: kind 0 clear, 1 load, 2 up, 3 down; len = drive cycles.
  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] data;
    logic [5:0] len;
  } ev_t;

  ev_t         log_q[$];
  ev_t         mon_e;
  int unsigned run_len = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      run_len = 0;
    end else if (!cnt_rst_n || enable) begin
      run_len = run_len + 1;
      if (done) begin
        mon_e.kind = !cnt_rst_n ? 2'd0 : load ? 2'd1 : up_down_n ? 2'd2 : 2'd3;
        mon_e.data = load ? data_input : 4'h0;
        mon_e.len  = 6'(run_len);
        log_q.push_back(mon_e);
        run_len = 0;
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [1:0] op, input logic [3:0] data, input logic [3:0] rep);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_rep   = rep;
  endtask

  // 4-bit counter fed by the sequencer outputs
  function automatic logic [3:0] model_step(input logic [3:0] v);
    if (!cnt_rst_n)            return 4'h0;
    else if (enable && load)   return data_input;
    else if (enable)           return up_down_n ? v + 4'h1 : v - 4'h1;
    else                       return v;
  endfunction

  logic [3:0] model;
  int         drv;
  int         dn;
  int         done_at;
  int         n;
  int         sz;
  ev_t        exp5[6];

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_data = 4'h0;
    cmd_rep = 4'h0;

    // Reset
    tick();
    chk("rst_ready",     32'(cmd_ready),  32'd0);
    chk("rst_cnt_rst_n", 32'(cnt_rst_n),  32'd1);
    chk("rst_enable",    32'(enable),     32'd0);
    chk("rst_load",      32'(load),       32'd0);
    chk("rst_busy",      32'(busy),       32'd0);
    chk("rst_done",      32'(done),       32'd0);
    chk("rst_data",      32'(data_input), 32'd0);
    tick();
    chk("rst_ready2",    32'(cmd_ready),  32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rel", 32'(cmd_ready), 32'd1);
    chk("updn_idle",       32'(up_down_n), 32'd1);

    // LOAD 4'hA
    set_cmd(2'b01, 4'hA, 4'h0);
    tick();
    cmd_valid = 1'b0;
    chk("ld_lat_load", 32'(load), 32'd0);
    chk("ld_lat_busy", 32'(busy), 32'd1);
    tick();
    chk("ld_load",   32'(load),       32'd1);
    chk("ld_enable", 32'(enable),     32'd1);
    chk("ld_data",   32'(data_input), 32'hA);
    chk("ld_done",   32'(done),       32'd1);
    tick();
    chk("ld_after_load", 32'(load),       32'd0);
    chk("ld_after_en",   32'(enable),     32'd0);
    chk("ld_after_done", 32'(done),       32'd0);
    chk("ld_after_busy", 32'(busy),       32'd0);
    chk("ld_data_hold",  32'(data_input), 32'hA);

    // UP rep=3
    model = 4'h0;
    drv = 0; dn = 0; done_at = 0;
    set_cmd(2'b10, 4'h0, 4'd3);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (enable && up_down_n && !load) drv++;
      if (done) begin dn++; done_at = drv; end
      model = model_step(model);
    end
    chk("up_cycles",  32'(drv),     32'd4);
    chk("up_dones",   32'(dn),      32'd1);
    chk("up_done_at", 32'(done_at), 32'd4);
    chk("up_model",   32'(model),   32'd4);

    // Back-to-back LOAD 5, DOWN rep=1, CLEAR
    model = 4'h0;
    set_cmd(2'b01, 4'h5, 4'h0);
    tick();
    set_cmd(2'b11, 4'h0, 4'd1);
    tick();
    chk("b2b_load", 32'(load), 32'd1);
    chk("b2b_ld_done", 32'(done), 32'd1);
    model = model_step(model);
    set_cmd(2'b00, 4'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_dn1", {29'd0, enable, up_down_n, done}, 32'b100);
    model = model_step(model);
    tick();
    chk("b2b_dn2", {29'd0, enable, up_down_n, done}, 32'b101);
    model = model_step(model);
    chk("b2b_model_pre_clr", 32'(model), 32'd3);
    tick();
    chk("b2b_clr", {29'd0, cnt_rst_n, enable, done}, 32'b001);
    model = model_step(model);
    chk("b2b_model_post_clr", 32'(model), 32'd0);
    tick();
    chk("b2b_idle", {30'd0, cnt_rst_n, busy}, 32'b10);

    // Back-pressure: UP rep=15 running, push DEPTH+1 commands
    log_q.delete();
    set_cmd(2'b10, 4'h0, 4'd15);
    tick();
    cmd_valid = 1'b0;
    tick();
    exp5[0] = '{kind: 2'd2, data: 4'h0, len: 6'd16};
    exp5[1] = '{kind: 2'd1, data: 4'h1, len: 6'd1};
    exp5[2] = '{kind: 2'd2, data: 4'h0, len: 6'd1};
    exp5[3] = '{kind: 2'd3, data: 4'h0, len: 6'd2};
    exp5[4] = '{kind: 2'd1, data: 4'h7, len: 6'd1};
    exp5[5] = '{kind: 2'd2, data: 4'h0, len: 6'd3};
    for (int i = 0; i < 5; i++) begin
      set_cmd(exp5[i+1].kind, exp5[i+1].data, 4'(exp5[i+1].len - 6'd1));
      n = 0;
      while (!cmd_ready && n < 40) begin
        tick();
        n++;
      end
      if (i < 4) chk($sformatf("bp_no_stall%0d", i), 32'(n), 32'd0);
      else       chk("bp_stall_cycles", 32'(n), 32'd12);
      tick();
      if (i == 3) chk("bp_ready_full", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    tick();
    chk("bp_drain_in_time", 32'(n < 100), 32'd1);
    chk("bp_log_size", 32'(log_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) chk($sformatf("bp_order%0d", i), 32'(log_q[i]), 32'(exp5[i]));
    end

    // Reset in the middle of UP rep=15 with two commands queued
    set_cmd(2'b10, 4'h0, 4'd15);
    tick();
    set_cmd(2'b01, 4'h3, 4'h0);
    tick();
    set_cmd(2'b11, 4'h0, 4'd2);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("abort_pre_en",   32'(enable), 32'd1);
    chk("abort_pre_done", 32'(done),   32'd0);
    sz = log_q.size();
    rst = 1'b1;
    tick();
    chk("abort_enable", 32'(enable),    32'd0);
    chk("abort_busy",   32'(busy),      32'd0);
    chk("abort_done",   32'(done),      32'd0);
    chk("abort_ready",  32'(cmd_ready), 32'd0);
    rst = 1'b0;
    drv = 0; dn = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (enable || load || !cnt_rst_n) drv++;
      if (done) dn++;
    end
    chk("abort_no_drive", 32'(drv),  32'd0);
    chk("abort_no_done",  32'(dn),   32'd0);
    chk("abort_busy_end", 32'(busy), 32'd0);
    chk("abort_log",      32'(log_q.size()), 32'(sz));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
